cpu_sequencer: RTL and testbench

Multi-cycle control unit for the 8-bit C0 datapath (regBank, ALU, flags register, B-input muxes). It owns the program counter and fetches 24-bit instruction words over a req/ack handshake. It decodes each word into the datapath select lines and strobes register and flag writes. It replaces hand-driven control and the free-running PC incrementer; conditional jumps are resolved inside this block.

---
 rtl/cpu_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit for the 8-bit C0 datapath: owns the PC, fetches
// 24-bit instruction words over req/ack, and drives the datapath select lines.
module cpu_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic              I_REQ,
  output logic [ADDR_W-1:0] I_ADDR,
  input  logic              I_ACK,
  input  logic [23:0]       I_DATA,
  input  logic [7:0]        FLAG,
  output logic [DATA_W-1:0] IMM,
  output logic [3:0]        opcode_alu,
  output logic [1:0]        MS,
  output logic [2:0]        RS,
  output logic [2:0]        AR,
  output logic [2:0]        BS,
  output logic              IRS,
  output logic              E,
  output logic              flagWbit,
  output logic              HALTED,
  output logic [2:0]        STATE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] C_ALUR = 3'b001;
  localparam logic [2:0] C_ALUI = 3'b010;
  localparam logic [2:0] C_MOVI = 3'b011;
  localparam logic [2:0] C_MOVR = 3'b100;
  localparam logic [2:0] C_JCC  = 3'b101;
  localparam logic [2:0] C_JMP  = 3'b110;
  localparam logic [2:0] C_HALT = 3'b111;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                req_q, req_d;
  logic [2:0]          cls_q, cls_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [3:0]          op_q, op_d;
  logic [1:0]          ms_q, ms_d;
  logic [2:0]          rs_q, rs_d;
  logic [2:0]          ar_q, ar_d;
  logic [2:0]          bs_q, bs_d;
  logic                irs_q, irs_d;
  logic                e_q, e_d;
  logic                fw_q, fw_d;
  logic                halted_q, halted_d;
  logic                take_q, take_d;

  // Fetch handshake: I_REQ is raised on entry to FETCH and, together with
  // I_ADDR, held stable until a rising edge sees I_ACK=1; that edge captures
  // I_DATA and drops I_REQ. I_ACK in any other state is ignored.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    cls_d    = cls_q;
    imm_d    = imm_q;
    op_d     = op_q;
    ms_d     = ms_q;
    rs_d     = rs_q;
    ar_d     = ar_q;
    bs_d     = bs_q;
    irs_d    = irs_q;
    e_d      = 1'b0;
    fw_d     = 1'b0;
    halted_d = halted_q;
    take_d   = take_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        req_d   = 1'b1;
      end
      S_FETCH: begin
        if (I_ACK) begin
          // Decode straight from the bus so the select lines are already
          // valid during DECODE and stay frozen through EXEC and WB.
          req_d   = 1'b0;
          state_d = S_DECODE;
          cls_d   = I_DATA[23:21];
          op_d    = I_DATA[20:17];
          rs_d    = I_DATA[16:14];
          ar_d    = I_DATA[13:11];
          bs_d    = I_DATA[10:8];
          imm_d   = DATA_W'(I_DATA[7:0]);
          irs_d   = (I_DATA[23:21] == C_ALUI);
          case (I_DATA[23:21])
            C_MOVI:  ms_d = 2'b10;
            C_MOVR:  ms_d = 2'b01;
            default: ms_d = 2'b00;
          endcase
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_WB;
        e_d     = (cls_q == C_ALUR) || (cls_q == C_ALUI) ||
                  (cls_q == C_MOVI) || (cls_q == C_MOVR);
        fw_d    = (cls_q == C_ALUR) || (cls_q == C_ALUI);
        // The jump condition is frozen here; FLAG may move during WB.
        take_d  = (cls_q == C_JMP) ||
                  ((cls_q == C_JCC) && (FLAG[bs_q] == op_q[0]));
      end
      S_WB: begin
        if (cls_q == C_HALT) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          req_d    = 1'b0;
        end else begin
          state_d = S_FETCH;
          req_d   = 1'b1;
          pc_d    = take_q ? ADDR_W'(imm_q) : pc_q + ADDR_W'(1);
        end
      end
      S_HALT: begin
        state_d = S_HALT;
        req_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      req_q    <= 1'b0;
      cls_q    <= '0;
      imm_q    <= '0;
      op_q     <= '0;
      ms_q     <= '0;
      rs_q     <= '0;
      ar_q     <= '0;
      bs_q     <= '0;
      irs_q    <= 1'b0;
      e_q      <= 1'b0;
      fw_q     <= 1'b0;
      halted_q <= 1'b0;
      take_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      cls_q    <= cls_d;
      imm_q    <= imm_d;
      op_q     <= op_d;
      ms_q     <= ms_d;
      rs_q     <= rs_d;
      ar_q     <= ar_d;
      bs_q     <= bs_d;
      irs_q    <= irs_d;
      e_q      <= e_d;
      fw_q     <= fw_d;
      halted_q <= halted_d;
      take_q   <= take_d;
    end
  end

  assign I_REQ      = req_q;
  assign I_ADDR     = pc_q;
  assign IMM        = imm_q;
  assign opcode_alu = op_q;
  assign MS         = ms_q;
  assign RS         = rs_q;
  assign AR         = ar_q;
  assign BS         = bs_q;
  assign IRS        = irs_q;
  assign E          = e_q;
  assign flagWbit   = fw_q;
  assign HALTED     = halted_q;
  assign STATE      = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: an instruction-memory driver feeds fetches and a
// decoupled monitor checks each instruction against an ISA-level model.
module tb_cpu_sequencer;

  logic        CLK;
  logic        RST_N;
  logic        I_REQ;
  logic [7:0]  I_ADDR;
  logic        I_ACK;
  logic [23:0] I_DATA;
  logic [7:0]  FLAG;
  logic [7:0]  IMM;
  logic [3:0]  opcode_alu;
  logic [1:0]  MS;
  logic [2:0]  RS, AR, BS;
  logic        IRS, E, flagWbit, HALTED;
  logic [2:0]  STATE;

  cpu_sequencer #(.ADDR_W(8), .DATA_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_ACK(I_ACK),
    .I_DATA(I_DATA), .FLAG(FLAG), .IMM(IMM), .opcode_alu(opcode_alu), .MS(MS),
    .RS(RS), .AR(AR), .BS(BS), .IRS(IRS), .E(E), .flagWbit(flagWbit),
    .HALTED(HALTED), .STATE(STATE)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [28:0] exp_q[$];   // {cls, E, flagWbit, MS, IRS, RS, AR, BS, op, imm}
  logic [7:0]  addr_q[$];
  logic [23:0] prog [256];
  logic [7:0]  m_pc;
  int          flag_force = -1;
  bit          mon_en = 1'b0;

  logic [38:0] all_outs;
  assign all_outs = {I_REQ, I_ADDR, IMM, opcode_alu, MS, RS, AR, BS,
                     IRS, E, flagWbit, HALTED, STATE};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] mk(input logic [2:0] c, input logic [3:0] op,
                                     input logic [2:0] rd, input logic [2:0] ra,
                                     input logic [2:0] rb, input logic [7:0] imm);
    return {c, op, rd, ra, rb, imm};
  endfunction

  // ISA-level view of what one instruction should show on the control lines.
  function automatic logic [28:0] exp_rec(input logic [23:0] w);
    logic [2:0] c;
    logic       wr, fl, irs;
    logic [1:0] ms;
    c   = w[23:21];
    wr  = c inside {3'b001, 3'b010, 3'b011, 3'b100};
    fl  = c inside {3'b001, 3'b010};
    irs = (c == 3'b010);
    ms  = (c == 3'b011) ? 2'b10 : (c == 3'b100) ? 2'b01 : 2'b00;
    return {c, wr, fl, ms, irs, w[16:14], w[13:11], w[10:8], w[20:17], w[7:0]};
  endfunction

  function automatic logic [7:0] next_pc(input logic [7:0] pc, input logic [23:0] w,
                                         input logic [7:0] f);
    case (w[23:21])
      3'b110:  return w[7:0];
      3'b101:  return (f[w[10:8]] == w[17]) ? w[7:0] : pc + 8'd1;
      default: return pc + 8'd1;
    endcase
  endfunction

  task automatic cmp_rec(input string name, input logic [28:0] rec);
    logic [28:0] act, mask;
    act  = {rec[28:26], E, flagWbit, MS, IRS, RS, AR, BS, opcode_alu, IMM};
    mask = '1;
    // MS/IRS only carry meaning for the four register-writing classes.
    if (!(rec[28:26] inside {3'b001, 3'b010, 3'b011, 3'b100})) mask[23:21] = 3'b000;
    check(name, 64'(act & mask), 64'(rec & mask));
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (mon_en && RST_N) begin
      case (STATE)
        3'd1: begin
          check("fetch_no_strobe", {E, flagWbit}, 2'b00);
          if (addr_q.size() > 0) begin
            check("fetch_req", I_REQ, 1'b1);
            check("fetch_addr", I_ADDR, addr_q[0]);
            if (I_ACK) void'(addr_q.pop_front());
          end
        end
        3'd2, 3'd3: begin
          if (exp_q.size() > 0) cmp_rec("decode_exec_lines", exp_q[0] & ~(29'h3 << 24));
          else check("unexpected_decode", STATE, 3'd1);
        end
        3'd4: begin
          if (exp_q.size() > 0) cmp_rec("wb_lines", exp_q.pop_front());
          else check("unexpected_wb", STATE, 3'd1);
        end
        default: check("idle_halt_no_strobe", {E, flagWbit}, 2'b00);
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    RST_N = 1'b0;
    I_ACK = 1'b0;
    I_DATA = 24'($urandom);
    FLAG = 8'($urandom);
    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs", all_outs, 39'd0);
    exp_q.delete();
    addr_q.delete();
    m_pc = 8'd0;
    RST_N = 1'b1;
  endtask

  task automatic serve(input int n, input int wmin, input int wmax, input bit stray);
    logic [23:0] w;
    logic [7:0]  f;
    int guard;
    for (int k = 0; k < n; k++) begin
      guard = 0;
      while (STATE !== 3'd1) begin
        I_ACK = 1'b0;
        if (stray && (STATE == 3'd2 || STATE == 3'd3) && $urandom_range(0, 1) == 1) begin
          I_ACK  = 1'b1;
          I_DATA = 24'($urandom);
        end
        @(posedge CLK);
        #1;
        guard++;
        if (guard > 40) begin
          I_ACK = 1'b0;
          check("fetch_timeout", STATE, 3'd1);
          return;
        end
      end
      I_ACK = 1'b0;
      w = prog[m_pc];
      f = (flag_force >= 0) ? 8'(flag_force) : 8'($urandom);
      FLAG = f;
      addr_q.push_back(m_pc);
      exp_q.push_back(exp_rec(w));
      repeat ($urandom_range(wmin, wmax)) begin
        @(posedge CLK);
        #1;
      end
      I_ACK  = 1'b1;
      I_DATA = w;
      @(posedge CLK);
      #1;
      I_ACK  = 1'b0;
      I_DATA = 24'($urandom);
      if (w[23:21] == 3'b111) return;
      m_pc = next_pc(m_pc, w, f);
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 20) begin
      @(posedge CLK);
      #1;
      g++;
    end
    check("drain_exp", exp_q.size(), 0);
    check("drain_addr", addr_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int g;
    RST_N = 1'b0;
    I_ACK = 1'b0;
    I_DATA = '0;
    FLAG = '0;
    foreach (prog[i]) prog[i] = '0;

    // Reset release with I_ACK tied high: raw state walk.
    do_reset();
    I_ACK  = 1'b1;
    I_DATA = mk(3'b000, 4'd0, 3'd0, 3'd0, 3'd0, 8'd0);
    @(negedge CLK); check("t1_idle", {STATE, I_REQ}, {3'd0, 1'b0});
    @(negedge CLK); check("t1_fetch", {STATE, I_REQ, I_ADDR}, {3'd1, 1'b1, 8'd0});
    @(negedge CLK); check("t1_decode", {STATE, I_REQ}, {3'd2, 1'b0});
    @(negedge CLK); check("t1_exec", STATE, 3'd3);
    @(negedge CLK); check("t1_wb", {STATE, E, flagWbit}, {3'd4, 2'b00});
    I_ACK = 1'b0;
    @(negedge CLK); check("t1_refetch", {STATE, I_REQ, I_ADDR}, {3'd1, 1'b1, 8'd1});
    @(posedge CLK);
    #1;
    mon_en = 1'b1;

    // MOVI, MOVI, ALU-R, taken JCC, not-taken JCC, HALT.
    do_reset();
    prog[0]     = mk(3'b011, 4'd0, 3'd0, 3'd0, 3'd0, 8'd5);
    prog[1]     = mk(3'b011, 4'd0, 3'd1, 3'd0, 3'd0, 8'd7);
    prog[2]     = mk(3'b001, 4'd0, 3'd0, 3'd0, 3'd1, 8'd0);
    prog[3]     = mk(3'b101, 4'b0001, 3'd0, 3'd0, 3'd3, 8'h40);
    prog[8'h40] = mk(3'b101, 4'b0001, 3'd0, 3'd0, 3'd3, 8'h40);
    prog[8'h41] = mk(3'b111, 4'd0, 3'd0, 3'd0, 3'd0, 8'd0);
    serve(3, 0, 2, 1'b0);
    flag_force = 8'h08;
    serve(1, 0, 1, 1'b0);
    flag_force = 8'hF7;
    serve(1, 0, 1, 1'b0);
    flag_force = -1;
    serve(1, 0, 1, 1'b0);
    g = 0;
    while (STATE !== 3'd5 && g < 10) begin
      @(posedge CLK);
      #1;
      g++;
    end
    repeat (20) begin
      @(negedge CLK);
      check("halt_hold", {HALTED, I_REQ, STATE}, {1'b1, 1'b0, 3'd5});
    end
    wait_drain();

    // PC wrap 0xFF -> 0x00.
    @(posedge CLK);
    #1;
    do_reset();
    prog[0]     = mk(3'b110, 4'd0, 3'd0, 3'd0, 3'd0, 8'hFF);
    prog[8'hFF] = mk(3'b000, 4'd3, 3'd2, 3'd4, 3'd6, 8'h11);
    serve(3, 0, 1, 1'b0);
    wait_drain();

    // Long fetch stall, then asynchronous reset in EXEC.
    do_reset();
    prog[0] = mk(3'b011, 4'd0, 3'd2, 3'd0, 3'd0, 8'h33);
    prog[1] = mk(3'b100, 4'd0, 3'd3, 3'd2, 3'd0, 8'h00);
    serve(1, 5, 5, 1'b0);
    @(posedge CLK);
    #1;
    check("t6_in_exec", STATE, 3'd3);
    RST_N = 1'b0;
    #1;
    check("t6_async_reset_outs", all_outs, 39'd0);
    exp_q.delete();
    addr_q.delete();
    m_pc = 8'd0;
    repeat (2) begin
      @(negedge CLK);
      check("t6_no_write_in_reset", {E, flagWbit}, 2'b00);
    end
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    serve(2, 0, 2, 1'b0);
    wait_drain();

    // Randomized program (no HALT) with stray acks and fetch stalls.
    do_reset();
    foreach (prog[i]) prog[i] = {3'($urandom_range(0, 6)), 21'($urandom)};
    serve(300, 0, 3, 1'b1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
